tanh_lut_loader: RTL and testbench

Owns the 1024×32 Q16.16 tanh table RAM used by the tanh interpolator, and is the write side of that table. It fills the RAM at run time from a byte stream and validates the payload with a trailing 32-bit checksum. It then serves two-address reads (index and index+1) to the interpolator. It sits between the host/config byte stream and the activation datapath, so the table can be reloaded without resynthesis.

---
 rtl/tanh_pkg.sv | 19 +
 rtl/tanh_lut_ram.sv | 32 +++
 rtl/tanh_lut_loader.sv | 127 ++++++++++++
 tb/tb_tanh_lut_loader.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/tanh_pkg.sv
// Shared constants and FSM state type for the tanh lookup table and its loader.
package tanh_pkg;

    localparam int FIXED      = 32;
    localparam int DEPTH_LOG2 = 10;
    localparam int CSUM_W     = 32;

    localparam logic [FIXED-1:0] Q_ONE       = 32'h0001_0000;
    localparam logic [FIXED-1:0] Q_MINUS_ONE = 32'hFFFF_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_READY,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/tanh_lut_ram.sv
// True dual-port table RAM: port A read/write, port B read-only, both with registered read data.
module tanh_lut_ram #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              en_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [WIDTH-1:0]  din_a,
    output logic [WIDTH-1:0]  q_a,
    input  logic              en_b,
    input  logic [ADDR_W-1:0] addr_b,
    output logic [WIDTH-1:0]  q_b
);

    (* ram_style = "block" *) logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (en_a) begin
            if (we_a)
                mem[addr_a] <= din_a;
            q_a <= mem[addr_a];
        end
    end

    always_ff @(posedge clk) begin
        if (en_b)
            q_b <= mem[addr_b];
    end

endmodule

// File: rtl/tanh_lut_loader.sv
// Loads the tanh table from a checksummed MSB-first byte stream, then serves paired reads.
module tanh_lut_loader #(
    parameter int FIXED      = tanh_pkg::FIXED,
    parameter int DEPTH_LOG2 = tanh_pkg::DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [7:0]            s_data,
    output logic                  busy,
    output logic                  table_valid,
    output logic                  error,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_addr0,
    input  logic [DEPTH_LOG2-1:0] rd_addr1,
    output logic                  rd_valid,
    output logic [FIXED-1:0]      rd_data0,
    output logic [FIXED-1:0]      rd_data1
);

    import tanh_pkg::*;

    state_t                  state;
    logic [1:0]              bcnt;
    logic [FIXED-9:0]        shreg;
    logic [DEPTH_LOG2-1:0]   waddr;
    logic [CSUM_W-1:0]       sum;

    logic                    accept;
    logic                    word_done;
    logic                    we;
    logic                    rd_fire;
    logic [FIXED-1:0]        word;
    logic [DEPTH_LOG2-1:0]   addr_a;
    logic [FIXED-1:0]        q_a;
    logic [FIXED-1:0]        q_b;

    assign accept    = s_valid & s_ready;
    assign word      = {shreg, s_data};
    assign word_done = accept & (bcnt == 2'd3);
    assign we        = word_done & (state == ST_LOAD);
    assign rd_fire   = rd_en & table_valid;
    // Port A belongs to the loader while writing; reads only reach it once the table is valid.
    assign addr_a    = we ? waddr : rd_addr0;

    tanh_lut_ram #(
        .WIDTH  (FIXED),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk    (clk),
        .en_a   (we | rd_fire),
        .we_a   (we),
        .addr_a (addr_a),
        .din_a  (word),
        .q_a    (q_a),
        .en_b   (rd_fire),
        .addr_b (rd_addr1),
        .q_b    (q_b)
    );

    assign rd_data0 = rd_valid ? q_a : '0;
    assign rd_data1 = rd_valid ? q_b : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            s_ready     <= 1'b0;
            busy        <= 1'b0;
            table_valid <= 1'b0;
            error       <= 1'b0;
            rd_valid    <= 1'b0;
            bcnt        <= '0;
            shreg       <= '0;
            waddr       <= '0;
            sum         <= '0;
        end else begin
            rd_valid <= rd_fire;
            case (state)
                ST_IDLE, ST_READY, ST_ERROR: begin
                    if (start) begin
                        state       <= ST_LOAD;
                        s_ready     <= 1'b1;
                        busy        <= 1'b1;
                        table_valid <= 1'b0;
                        error       <= 1'b0;
                        bcnt        <= '0;
                        waddr       <= '0;
                        sum         <= '0;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        bcnt  <= bcnt + 2'd1;
                        shreg <= word[FIXED-9:0];
                    end
                    if (word_done) begin
                        sum   <= sum + CSUM_W'(word);
                        waddr <= waddr + 1'b1;
                        if (waddr == '1)
                            state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (accept) begin
                        bcnt  <= bcnt + 2'd1;
                        shreg <= word[FIXED-9:0];
                    end
                    if (word_done) begin
                        s_ready <= 1'b0;
                        busy    <= 1'b0;
                        if (CSUM_W'(word) == sum) begin
                            state       <= ST_READY;
                            table_valid <= 1'b1;
                        end else begin
                            state <= ST_ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tanh_lut_loader.sv
// Directed self-checking bench for tanh_lut_loader: loads, checksum pass/fail, reads, reset and restart.
module tb_tanh_lut_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        busy;
    logic        table_valid;
    logic        error;
    logic        rd_en;
    logic [9:0]  rd_addr0;
    logic [9:0]  rd_addr1;
    logic        rd_valid;
    logic [31:0] rd_data0;
    logic [31:0] rd_data1;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    bit          stall_seen = 0;

    tanh_lut_loader #(
        .FIXED      (32),
        .DEPTH_LOG2 (10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .busy        (busy),
        .table_valid (table_valid),
        .error       (error),
        .rd_en       (rd_en),
        .rd_addr0    (rd_addr0),
        .rd_addr1    (rd_addr1),
        .rd_valid    (rd_valid),
        .rd_data0    (rd_data0),
        .rd_data1    (rd_data1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ramp(input int i);
        return 32'(i) << 8;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int unsigned w;
        w = 0;
        s_data  = b;
        s_valid = 1'b1;
        while (!s_ready && w < 8 && !stall_seen) begin
            tick();
            w++;
        end
        if (!s_ready && !stall_seen) begin
            stall_seen = 1'b1;
            check("s_ready_wait", {95'b0, s_ready}, 96'd1);
        end
        tick();
        s_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++)
            send_byte(w[31-8*k -: 8]);
    endtask

    // n payload words; ffmode selects constant 0xFFFF0000, else the ramp i<<8
    task automatic load_words(input int n, input bit ffmode, input int gap_pct, input int start_at);
        for (int i = 0; i < n; i++) begin
            if (gap_pct > 0)
                while ($urandom_range(99) < gap_pct) tick();
            if (i == start_at) begin
                pulse_start();
                check("start_ignored_busy", {94'b0, busy, s_ready}, 96'b11);
            end
            send_word(ffmode ? 32'hFFFF_0000 : ramp(i));
        end
    endtask

    task automatic send_csum(input logic [31:0] c, input bit pass, input string tag);
        for (int k = 0; k < 3; k++)
            send_byte(c[31-8*k -: 8]);
        check({tag, "_pre"}, {92'b0, busy, s_ready, table_valid, error}, {92'b0, 4'b1100});
        send_byte(c[7:0]);
        check({tag, "_post"}, {92'b0, busy, s_ready, table_valid, error},
              {92'b0, 1'b0, 1'b0, pass, ~pass});
    endtask

    task automatic read2(input logic [9:0] a0, input logic [9:0] a1,
                         input logic e_v, input logic [31:0] e0, input logic [31:0] e1,
                         input string tag);
        rd_addr0 = a0;
        rd_addr1 = a1;
        rd_en    = 1'b1;
        tick();
        rd_en = 1'b0;
        check(tag, {31'b0, rd_valid, rd_data0, rd_data1}, {31'b0, e_v, e0, e1});
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        rd_en    = 1'b0;
        rd_addr0 = '0;
        rd_addr1 = '0;
        tick();
        tick();
        check("reset_outputs", {29'b0, s_ready, busy, table_valid, error, rd_valid, rd_data0, rd_data1}, 96'd0);
        rst_n = 1'b1;
        tick();

        read2(10'h010, 10'h011, 1'b0, 32'h0, 32'h0, "read_before_load");

        // Ramp load at full rate, with a start pulse mid-load that must be ignored
        pulse_start();
        check("load_entry", {94'b0, busy, s_ready}, 96'b11);
        load_words(1024, 1'b0, 0, 300);
        send_csum(32'h07FE_0000, 1'b1, "ramp_pass");
        read2(10'h167, 10'h168, 1'b1, 32'h0001_6700, 32'h0001_6800, "read_167_168");
        tick();
        check("read_idle_zero", {31'b0, rd_valid, rd_data0, rd_data1}, 96'd0);
        read2(10'h3FF, 10'h3FF, 1'b1, 32'h0003_FF00, 32'h0003_FF00, "read_same_addr");
        read2(10'h3FF, 10'h000, 1'b1, 32'h0003_FF00, 32'h0000_0000, "read_wrap_pair");

        // Back-to-back reads over every index, neighbour wraps 1023 -> 0
        rd_addr0 = 10'd0;
        rd_addr1 = 10'd1;
        rd_en    = 1'b1;
        tick();
        for (int i = 1; i <= 1024; i++) begin
            check("b2b_read", {31'b0, rd_valid, rd_data0, rd_data1},
                  {31'b0, 1'b1, ramp(i-1), ramp(i % 1024)});
            if (i < 1024) begin
                rd_addr0 = 10'(i);
                rd_addr1 = 10'((i + 1) % 1024);
            end else begin
                rd_en = 1'b0;
            end
            tick();
        end
        check("b2b_after", {95'b0, rd_valid}, 96'd0);

        // Restart from READY; table_valid drops one cycle after start
        check("ready_no_consume", {95'b0, s_ready}, 96'd0);
        pulse_start();
        check("restart_tv_drop", {93'b0, table_valid, busy, s_ready}, 96'b011);
        load_words(1024, 1'b0, 0, -1);
        send_csum(32'h07FE_0001, 1'b0, "ramp_bad_csum");
        read2(10'h167, 10'h168, 1'b0, 32'h0, 32'h0, "read_after_error");

        // Ramp with ~30% idle cycles on the stream
        pulse_start();
        check("error_cleared", {94'b0, error, table_valid}, 96'd0);
        load_words(1024, 1'b0, 30, -1);
        send_csum(32'h07FE_0000, 1'b1, "gap_pass");
        read2(10'h000, 10'h3FF, 1'b1, 32'h0000_0000, 32'h0003_FF00, "gap_read_ends");
        read2(10'h200, 10'h201, 1'b1, 32'h0002_0000, 32'h0002_0100, "gap_read_mid");

        // Reset in the middle of a load
        pulse_start();
        load_words(501, 1'b0, 0, -1);
        check("midload_busy", {95'b0, busy}, 96'd1);
        rst_n = 1'b0;
        #1;
        check("midload_reset", {29'b0, s_ready, busy, table_valid, error, rd_valid, rd_data0, rd_data1}, 96'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_reset_idle", {94'b0, busy, s_ready}, 96'd0);

        // 1024 x 0xFFFF0000 summed mod 2^32 is 0xFC000000
        pulse_start();
        load_words(1024, 1'b1, 0, -1);
        send_csum(32'hFC00_0000, 1'b1, "ff_pass");
        read2(10'h000, 10'h3FF, 1'b1, 32'hFFFF_0000, 32'hFFFF_0000, "ff_read_ends");
        read2(10'h1F4, 10'h1F5, 1'b1, 32'hFFFF_0000, 32'hFFFF_0000, "ff_read_w500");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
